// File: rtl/seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_ctrl_pkg
// Purpose  : State encoding and default widths for the sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package seq_ctrl_pkg;

  localparam int c_default_pw = 8;
  localparam int c_default_cw = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : seq_prescaler
// Purpose  : Step-period prescaler; ticks once every max(period,1) enabled clocks.
// Revision : 1.0 - initial release
// ============================================================================
module seq_prescaler #(
  parameter int PW = seq_ctrl_pkg::c_default_pw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_top;
  logic          w_last;

  // A period of zero behaves as one: the counter sits at zero and ticks every clock.
  assign w_top  = (period == '0) ? '0 : period - 1'b1;
  assign w_last = (r_cnt == w_top);
  assign tick   = enable && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_fsm_ctrl
// Purpose  : Clear/step sequencing controller for the 3-bit generator FSMs.
//            Optional lockstep comparator enabled by SEQ_LOCKSTEP_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_fsm_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PW = c_default_pw,
  parameter int CW = c_default_cw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          step,
  input  logic [PW-1:0] period,
  input  logic [CW-1:0] len,
  output logic          gen_clr,
  output logic          gen_en,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] step_cnt,
  input  logic [2:0]    std_out,
  input  logic [2:0]    man_out,
  output logic          mismatch
);

  state_t        r_state;
  logic          r_gen_clr;
  logic          r_gen_en;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_step_cnt;
  logic [PW-1:0] r_period;
  logic [CW-1:0] r_len;

  logic w_tick;
  logic w_start_run;
  logic w_len_hit;
  logic w_abort;

  assign w_start_run = (r_state == ST_IDLE) && start && !stop;
  // Evaluated in the gen_en cycle, so done follows the final step by one clock.
  assign w_len_hit   = (r_len != '0) && r_gen_en && (r_step_cnt == r_len);

  seq_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (r_state == ST_CLEAR),
    .enable (r_state == ST_RUN),
    .period (r_period),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gen_clr  <= 1'b0;
      r_gen_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_step_cnt <= '0;
      r_period   <= '0;
      r_len      <= '0;
    end else begin
      r_gen_clr <= 1'b0;
      r_gen_en  <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_run) begin
            r_state    <= ST_CLEAR;
            r_gen_clr  <= 1'b1;
            r_busy     <= 1'b1;
            r_step_cnt <= '0;
            r_period   <= period;
            r_len      <= len;
          end else if (step && !stop) begin
            r_gen_en   <= 1'b1;
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (stop) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Leaving RUN swallows any tick due in the same cycle.
          if (stop || w_len_hit || w_abort) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_tick) begin
            r_gen_en   <= 1'b1;
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gen_clr  = r_gen_clr;
  assign gen_en   = r_gen_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_cnt = r_step_cnt;

`ifdef SEQ_LOCKSTEP_CHECK_EN
  logic r_gen_en_d;
  logic r_mismatch;

  // Compare one clock after each step, once both generators have advanced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gen_en_d <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_gen_en_d <= r_gen_en;
      if (w_start_run) begin
        r_mismatch <= 1'b0;
      end else if (r_gen_en_d && (std_out != man_out)) begin
        r_mismatch <= 1'b1;
      end
    end
  end

  assign w_abort  = r_mismatch;
  assign mismatch = r_mismatch;
`else
  logic w_unused_lockstep;
  assign w_unused_lockstep = ^{std_out, man_out};
  assign w_abort  = 1'b0;
  assign mismatch = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/seq_fsm_ctrl.md
Name: seq_fsm_ctrl

Overview:
- Sequencing controller for the 3-bit sequence-generator FSMs (standard-coded and manually-coded variants) used in the hazi1 homework block.
- Generates the FSM's synchronous clear and step-enable ticks from a programmable prescaler.
- Runs a programmable number of steps, supports start/stop/single-step, and reports progress.
- Sits between the board-level buttons/switches and the generator FSM instance.

Parameters:
- PW, 8, width of step-period prescaler value.
- CW, 8, width of step-length and step counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begin a run.
- stop  in  1  one-cycle pulse; abort a run.
- step  in  1  one-cycle pulse; single step when idle.
- period  in  PW  clocks per step; 0 is treated as 1.
- len  in  CW  steps per run; 0 means run until stop.
- gen_clr  out  1  synchronous clear to generator FSM.
- gen_en  out  1  one-cycle step enable to generator FSM.
- busy  out  1  high in CLEAR or RUN.
- done  out  1  one-cycle pulse at run completion or stop.
- step_cnt  out  CW  gen_en pulses issued since last clear.
- std_out  in  3  generator output (checker only).
- man_out  in  3  second generator output (checker only).
- mismatch  out  1  sticky lockstep error (checker only).

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, prescaler 0, step_cnt 0.
- Reset mid-run aborts immediately. No done pulse is issued.
- All outputs are registered.
- States and transitions:
  - IDLE, start=1: go to CLEAR.
  - IDLE, step=1, start=0: one gen_en pulse on the next cycle; step_cnt+1. Stay in IDLE.
  - CLEAR: gen_clr=1 for exactly one cycle. step_cnt and prescaler set to 0. period and len latched into shadow registers. Next state RUN.
  - RUN: prescaler counts 0..P-1, where P = max(latched period, 1). gen_en=1 in the cycle after the prescaler reaches P-1; the prescaler then wraps to 0. First gen_en occurs P cycles after entering RUN.
  - RUN: each gen_en increments step_cnt, which wraps at 2^CW.
  - RUN, latched len≠0: when step_cnt reaches len (on that gen_en cycle), next state DONE.
  - RUN, stop=1: next state DONE. A gen_en due in the same cycle is suppressed.
  - DONE: done=1 for one cycle, then IDLE. step_cnt holds its value.
- Input precedence:
  - stop has priority over start and step in all states.
  - In IDLE, stop is ignored (no done pulse).
  - start during CLEAR/RUN/DONE is ignored. step during those states is ignored.
- Changes to period/len during a run have no effect until the next CLEAR.
- With P=1, gen_en is high every RUN cycle. len=1 gives exactly one gen_en and then DONE.

Optional Feature:
- Macro: SEQ_LOCKSTEP_CHECK_EN.
- Defined: std_out and man_out are compared in the cycle after each gen_en (both FSMs have updated). Any difference sets mismatch=1.
  - mismatch is sticky until rst or the next CLEAR.
  - A mismatch forces RUN to DONE on the following cycle.
- Undefined: std_out, man_out unused; mismatch tied to 0; no comparator logic.

Decomposition:
- Package seq_ctrl_pkg: state encoding (IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3) and default PW/CW constants.
- One sub-module seq_prescaler:
  - Inputs: clear, enable, period.
  - Output: tick.
  - Implements the max(period,1) rule.

Test Plan:
- rst pulse mid-run (period=4, len=0) → all outputs 0 in the same cycle; state IDLE; no done.
- start, period=3, len=4 → gen_clr 1 cycle later; gen_en every 3rd clock; step_cnt 1,2,3,4; done exactly one cycle after the 4th gen_en; busy low afterwards.
- period=0, len=5 → gen_en high on 5 consecutive clocks; step_cnt=5; done.
- len=0, period=2, stop after 7 steps with stop coincident with a due tick → tick suppressed; step_cnt=7; done pulse; start+stop together → stays IDLE.
- IDLE step pulse ×3 → three gen_en pulses; step_cnt=3; no gen_clr; busy stays 0.
- SEQ_LOCKSTEP_CHECK_EN defined: man_out forced to 3'b101 while std_out=3'b001 after 2nd tick → mismatch=1; RUN ends with done; mismatch cleared by next start's CLEAR.
